// File: rtl/cflog_writer_pkg.sv
// Shared definitions for the control-flow log writer: log placement,
// event word widths and drain FSM state encodings.
package cflog_writer_pkg;

  localparam logic [15:0] LOG_BASE_DEF = 16'h0230;
  localparam int          WORD_W       = 16;
  localparam int          EVT_W        = 2 * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_SRC = 2'd1,
    ST_WR_DST = 2'd2,
    ST_FULL   = 2'd3
  } drain_state_e;

  function automatic logic [EVT_W-1:0] pack_evt(input logic [WORD_W-1:0] src,
                                                input logic [WORD_W-1:0] dst);
    return {src, dst};
  endfunction

endpackage

// File: rtl/cflog_fifo.sv
// Synchronous FIFO of packed {src,dst} events. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module cflog_fifo
  import cflog_writer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [EVT_W-1:0] din,
  output logic [EVT_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [EVT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cflog_writer.sv
// Control-flow log producer: captures (src,dst) PC pairs on control transfers
// and writes them as two words into the LOG region through a private port.
module cflog_writer
  import cflog_writer_pkg::*;
#(
  parameter logic [15:0] LOG_BASE   = LOG_BASE_DEF,
  parameter logic [15:0] LOG_SIZE   = 16'h0100,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instr_valid,
  input  logic        cf_instr,
  input  logic        attest_req,
  input  logic        log_clear,
  output logic        log_wr_en,
  output logic [15:0] log_wr_addr,
  output logic [15:0] log_wr_data,
  input  logic        log_wr_ready,
  output logic [15:0] log_ptr,
  output logic        log_full,
  output logic        log_overflow,
  output logic        attest_ack
);

  // state     | meaning
  // ST_IDLE   | waiting for a buffered event with room in the log
  // ST_WR_SRC | presenting source word until accepted
  // ST_WR_DST | presenting destination word; pop event on accept
  // ST_FULL   | no room left; discard all events until log_clear

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drain_state_e     state_q, state_d;
  logic [15:0]      log_ptr_q, log_ptr_d;
  logic [15:0]      prev_pc_q, prev_pc_d;
  logic             cf_pending_q, cf_pending_d;
  logic             overflow_q, overflow_d;
  logic             ack_q, ack_d;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty, has_room;
  logic [EVT_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;

  // 17-bit compare so a pointer near the top of the space cannot wrap.
  assign has_room = ({1'b0, log_ptr_q} + 17'd4) <= {1'b0, LOG_SIZE};

  cflog_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (pack_evt(prev_pc_q, pc)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    log_ptr_d    = log_ptr_q;
    prev_pc_d    = prev_pc_q;
    cf_pending_d = cf_pending_q;
    overflow_d   = overflow_q;
    ack_d        = ack_q;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;

    if (attest_req) begin
      cf_pending_d = 1'b0;
    end else if (instr_valid) begin
      push         = cf_pending_q;
      cf_pending_d = cf_instr;
      prev_pc_d    = pc;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = has_room ? ST_WR_SRC : ST_FULL;
      end
      ST_WR_SRC: begin
        if (log_wr_ready) begin
          log_ptr_d = log_ptr_q + 16'd2;
          state_d   = ST_WR_DST;
        end
      end
      ST_WR_DST: begin
        if (log_wr_ready) begin
          log_ptr_d = log_ptr_q + 16'd2;
          pop       = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_FULL: begin
        flush = 1'b1;
        if (push || fifo_count != '0) overflow_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push && fifo_full && !pop) overflow_d = 1'b1;

    if (!attest_req) begin
      ack_d = 1'b0;
    end else if ((state_q == ST_IDLE || state_q == ST_FULL) && fifo_empty) begin
      ack_d = 1'b1;
    end

    if (log_clear && ack_q) begin
      log_ptr_d  = 16'd0;
      overflow_d = 1'b0;
      state_d    = ST_IDLE;
      flush      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      log_ptr_q    <= 16'd0;
      prev_pc_q    <= 16'd0;
      cf_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      log_ptr_q    <= log_ptr_d;
      prev_pc_q    <= prev_pc_d;
      cf_pending_q <= cf_pending_d;
      overflow_q   <= overflow_d;
      ack_q        <= ack_d;
    end
  end

  assign log_wr_en    = (state_q == ST_WR_SRC) || (state_q == ST_WR_DST);
  assign log_wr_addr  = LOG_BASE + log_ptr_q;
  assign log_wr_data  = (state_q == ST_WR_DST) ? fifo_dout[WORD_W-1:0]
                                               : fifo_dout[EVT_W-1:WORD_W];
  assign log_ptr      = log_ptr_q;
  assign log_full     = (state_q == ST_FULL) || !has_room;
  assign log_overflow = overflow_q;
  assign attest_ack   = ack_q;

endmodule

// File: tb/tb_cflog_writer.sv
// Self-checking bench for cflog_writer: directed vector table, hand-written
// corner sequences and randomized rounds against an event-level model.
module tb_cflog_writer;

  localparam logic [15:0] BASE = 16'h0230;
  localparam logic [15:0] SIZE = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0;
  logic        instr_valid = 1'b0, cf_instr = 1'b0;
  logic        attest_req = 1'b0, log_clear = 1'b0;
  logic        log_wr_ready = 1'b0;
  logic        log_wr_en, log_full, log_overflow, attest_ack;
  logic [15:0] log_wr_addr, log_wr_data, log_ptr;

  always #5 clk = ~clk;

  cflog_writer #(.LOG_BASE(BASE), .LOG_SIZE(SIZE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr_valid(instr_valid),
    .cf_instr(cf_instr), .attest_req(attest_req), .log_clear(log_clear),
    .log_wr_en(log_wr_en), .log_wr_addr(log_wr_addr), .log_wr_data(log_wr_data),
    .log_wr_ready(log_wr_ready), .log_ptr(log_ptr), .log_full(log_full),
    .log_overflow(log_overflow), .attest_ack(attest_ack)
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];

  // Completed writes, observed mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    if (!reset && log_wr_en && log_wr_ready) begin
      q_addr.push_back(log_wr_addr);
      q_data.push_back(log_wr_data);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; cf_instr = 1'b0;
    attest_req = 1'b0; log_clear = 1'b0;
    step(); step();
    reset = 1'b0;
    clear_q();
  endtask

  task automatic instr(input logic [15:0] p, input logic cf);
    pc = p; cf_instr = cf; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; cf_instr = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) step();
    check("write_count", q_data.size(), n);
  endtask

  task automatic wait_wr_en(input int budget);
    for (int i = 0; i < budget && !log_wr_en; i++) step();
    check("wr_en_rise", log_wr_en, 1);
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget && !attest_ack; i++) step();
    check("ack_rise", attest_ack, 1);
  endtask

  task automatic check_wr(input string nm, input int i, input logic [15:0] ea, input logic [15:0] ed);
    logic [15:0] a, d;
    a = (i < q_addr.size()) ? q_addr[i] : 16'hxxxx;
    d = (i < q_data.size()) ? q_data[i] : 16'hxxxx;
    check({nm, "_addr"}, a, ea);
    check({nm, "_data"}, d, ed);
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    int          stall;
    logic [15:0] addr;
    logic [15:0] ptr;
    logic        full;
  } vec_t;

  vec_t vt[4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] ev_src[$];
    logic [15:0] ev_dst[$];
    logic        pend;
    logic [15:0] prev;
    int          nexp;

    vt[0] = '{16'hE010, 16'hE100, 0, 16'h0230, 16'h0004, 1'b0};
    vt[1] = '{16'hE020, 16'hE200, 3, 16'h0234, 16'h0008, 1'b0};
    vt[2] = '{16'hF000, 16'hE000, 1, 16'h0238, 16'h000C, 1'b0};
    vt[3] = '{16'h1234, 16'h5678, 2, 16'h023C, 16'h0010, 1'b1};

    do_reset();
    check("rst_wr_en", log_wr_en, 0);
    check("rst_ptr", log_ptr, 0);
    check("rst_full", log_full, 0);
    check("rst_ovf", log_overflow, 0);
    check("rst_ack", attest_ack, 0);

    // Directed table: one event per row, with optional write-port stall.
    for (int r = 0; r < 4; r++) begin
      clear_q();
      log_wr_ready = (vt[r].stall == 0);
      instr(vt[r].src, 1'b1);
      instr(vt[r].dst, 1'b0);
      if (vt[r].stall > 0) begin
        wait_wr_en(20);
        for (int s = 0; s < vt[r].stall; s++) begin
          check("stall_en", log_wr_en, 1);
          check("stall_addr", log_wr_addr, vt[r].addr);
          check("stall_data", log_wr_data, vt[r].src);
          step();
        end
        check("stall_nowrite", q_data.size(), 0);
        log_wr_ready = 1'b1;
      end
      wait_writes(2, 20);
      repeat (3) step();
      check("vec_count", q_data.size(), 2);
      check_wr("vec_src", 0, vt[r].addr, vt[r].src);
      check_wr("vec_dst", 1, vt[r].addr + 16'd2, vt[r].dst);
      check("vec_ptr", log_ptr, vt[r].ptr);
      check("vec_full", log_full, vt[r].full);
      check("vec_ovf", log_overflow, 0);
    end
    clear_q();
    instr(16'hE500, 1'b1);
    instr(16'hE600, 1'b0);
    repeat (6) step();
    check("full_nowrite", q_data.size(), 0);
    check("full_flag", log_full, 1);
    check("full_ovf", log_overflow, 1);
    check("full_ptr", log_ptr, 16'h0010);

    // FIFO overflow: 6 events with the port stalled, 4 survive.
    do_reset();
    log_wr_ready = 1'b0;
    for (int i = 0; i < 7; i++) instr(16'hA000 + 16'(2 * i), 1'b1);
    check("fovf_flag", log_overflow, 1);
    check("fovf_nowrite", q_data.size(), 0);
    log_wr_ready = 1'b1;
    wait_writes(8, 60);
    repeat (5) step();
    check("fovf_exact", q_data.size(), 8);
    for (int k = 0; k < 4; k++) begin
      check_wr("fovf_src", 2 * k, BASE + 16'(4 * k), 16'hA000 + 16'(2 * k));
      check_wr("fovf_dst", 2 * k + 1, BASE + 16'(4 * k + 2), 16'hA000 + 16'(2 * k + 2));
    end
    check("fovf_ptr", log_ptr, 16'h0010);

    // log_clear outside attestation is ignored; inside it clears everything.
    log_clear = 1'b1; step(); log_clear = 1'b0; step();
    check("clr_ign_ptr", log_ptr, 16'h0010);
    check("clr_ign_ovf", log_overflow, 1);
    attest_req = 1'b1;
    wait_ack(10);
    log_clear = 1'b1; step(); log_clear = 1'b0;
    check("clr_ptr", log_ptr, 0);
    check("clr_ovf", log_overflow, 0);
    check("clr_full", log_full, 0);
    check("clr_ack_hold", attest_ack, 1);
    attest_req = 1'b0; step();
    check("ack_fall", attest_ack, 0);

    // Attestation with two events buffered; no capture across the boundary.
    clear_q();
    log_wr_ready = 1'b0;
    instr(16'hB000, 1'b1);
    instr(16'hB010, 1'b1);
    instr(16'hB020, 1'b1);
    attest_req = 1'b1;
    step();
    check("att_ack_wait", attest_ack, 0);
    log_wr_ready = 1'b1;
    instr(16'hC000, 1'b1);
    instr(16'hC010, 1'b0);
    wait_ack(40);
    check("att_count", q_data.size(), 4);
    check_wr("att_w0", 0, 16'h0230, 16'hB000);
    check_wr("att_w1", 1, 16'h0232, 16'hB010);
    check_wr("att_w2", 2, 16'h0234, 16'hB010);
    check_wr("att_w3", 3, 16'h0236, 16'hB020);
    check("att_ptr", log_ptr, 16'h0008);
    attest_req = 1'b0; step();
    instr(16'hD000, 1'b0);
    repeat (6) step();
    check("att_nocross", q_data.size(), 4);
    check("att_ptr_after", log_ptr, 16'h0008);

    // Reset abandons a write stalled in the destination phase.
    do_reset();
    log_wr_ready = 1'b0;
    instr(16'hE010, 1'b1);
    instr(16'hE100, 1'b0);
    wait_wr_en(20);
    log_wr_ready = 1'b1; step(); log_wr_ready = 1'b0;
    check("rdst_en", log_wr_en, 1);
    check("rdst_addr", log_wr_addr, 16'h0232);
    check("rdst_data", log_wr_data, 16'hE100);
    reset = 1'b1; step(); reset = 1'b0;
    check("rdst_en_low", log_wr_en, 0);
    check("rdst_ptr", log_ptr, 0);
    clear_q();
    log_wr_ready = 1'b1;
    repeat (6) step();
    check("rdst_fifo_empty", q_data.size(), 0);
    instr(16'hE020, 1'b1);
    instr(16'hE200, 1'b0);
    wait_writes(2, 20);
    check_wr("rdst_src", 0, 16'h0230, 16'hE020);
    check_wr("rdst_dst", 1, 16'h0232, 16'hE200);

    // Randomized rounds. With a 4-event log and 4-deep buffer, the log always
    // holds exactly the first min(n,4) captured pairs; anything beyond is lost.
    for (int rnd = 0; rnd < 8; rnd++) begin
      do_reset();
      ev_src.delete(); ev_dst.delete();
      pend = 1'b0; prev = 16'h0000;
      for (int c = 0; c < 10 + 6 * rnd; c++) begin
        instr_valid  = ($urandom_range(0, 9) < 1 + rnd);
        cf_instr     = ($urandom_range(0, 2) == 0);
        pc           = 16'($urandom) & 16'hFFFE;
        log_wr_ready = ($urandom_range(0, 2) != 0);
        if (instr_valid) begin
          if (pend) begin
            ev_src.push_back(prev);
            ev_dst.push_back(pc);
          end
          pend = cf_instr;
          prev = pc;
        end
        step();
      end
      instr_valid = 1'b0; cf_instr = 1'b0; log_wr_ready = 1'b1;
      repeat (30) step();
      attest_req = 1'b1;
      wait_ack(30);
      nexp = (ev_src.size() < 4) ? ev_src.size() : 4;
      check("rnd_count", q_data.size(), 2 * nexp);
      for (int k = 0; k < nexp; k++) begin
        check_wr("rnd_src", 2 * k, BASE + 16'(4 * k), ev_src[k]);
        check_wr("rnd_dst", 2 * k + 1, BASE + 16'(4 * k + 2), ev_dst[k]);
      end
      check("rnd_ptr", log_ptr, 16'(4 * nexp));
      check("rnd_ovf", log_overflow, (ev_src.size() > 4));
      check("rnd_full", log_full, (nexp == 4));
      log_clear = 1'b1; step(); log_clear = 1'b0;
      check("rnd_clr_ptr", log_ptr, 0);
      check("rnd_clr_ovf", log_overflow, 0);
      attest_req = 1'b0; step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
